// File: rtl/tree_pkg.sv
// Shared widths, node-word field layout and loader state encoding for tree_loader.
// TREE_LOADER_PARENT_CHECK_EN adds the DRAIN state used by the parent check.
package tree_pkg;

    localparam int MAX_NODES = 1024;
    localparam int W_ADDR    = 10;
    localparam int W_CONF    = 11;
    localparam int W_ACTION  = 3;
    localparam int W_REWARD  = 12;
    localparam int W_WEIGHT  = 7;
    localparam int W_DATA    = W_REWARD;

    // Node-word field positions (LSB of each field)
    localparam int PAR_LSB = 22;
    localparam int ACT_LSB = 19;
    localparam int REW_LSB = 7;
    localparam int WGT_LSB = 0;

    typedef struct packed {
        logic [W_ADDR-1:0]   parent;
        logic [W_ACTION-1:0] action;
        logic [W_REWARD-1:0] reward;
        logic [W_WEIGHT-1:0] weight;
    } node_word_t;

`ifdef TREE_LOADER_PARENT_CHECK_EN
    typedef enum logic [3:0] {
        S_IDLE, S_CONF, S_NODE_WAIT, S_E_PAR, S_E_ACT, S_E_REW, S_E_WGT, S_DONE, S_DRAIN
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_CONF, S_NODE_WAIT, S_E_PAR, S_E_ACT, S_E_REW, S_E_WGT, S_DONE
    } state_t;
`endif

endpackage

// File: rtl/tree_loader_if.sv
// Valid/ready stream carrying the header beat followed by packed node words.
interface tree_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/tree_node_unpack.sv
// Splits a node word into its four fields, each zero-extended to the mem_data width.
module tree_node_unpack
    import tree_pkg::*;
(
    input  logic [31:0]       word,
    output logic [W_DATA-1:0] parent,
    output logic [W_DATA-1:0] action,
    output logic [W_DATA-1:0] reward,
    output logic [W_DATA-1:0] weight
);
    assign parent = W_DATA'(word[PAR_LSB +: W_ADDR]);
    assign action = W_DATA'(word[ACT_LSB +: W_ACTION]);
    assign reward = W_DATA'(word[REW_LSB +: W_REWARD]);
    assign weight = W_DATA'(word[WGT_LSB +: W_WEIGHT]);
endmodule

// File: rtl/tree_loader.sv
// Replays a framed node stream onto the tree engine's one-field-per-cycle load port.
// Optional TREE_LOADER_PARENT_CHECK_EN: forward-pointing parents abort the load and drain the frame.
module tree_loader
    import tree_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    tree_loader_if.slave      s,
    output logic              conf_nodes,
    output logic [W_CONF-1:0] conf_data,
    output logic              mem_par,
    output logic              mem_act,
    output logic              mem_rew,
    output logic              mem_weight,
    output logic [W_ADDR-1:0] mem_addr,
    output logic [W_DATA-1:0] mem_data,
    output logic              tv_rst,
    output logic              load_done,
    output logic              err
);
    state_t            state, state_n;
    logic [W_ADDR-1:0] addr_q, addr_n, last_q, last_n;
    node_word_t        word_q, word_n;
    logic              s_ready_q, s_ready_n;
    logic              conf_nodes_n, mem_par_n, mem_act_n, mem_rew_n, mem_weight_n;
    logic              tv_rst_n, load_done_n, err_n;
    logic [W_CONF-1:0] conf_data_n;
    logic [W_ADDR-1:0] mem_addr_n;
    logic [W_DATA-1:0] mem_data_n;

    logic              acc;
    logic [W_CONF-1:0] hdr_cnt;
    logic [31:0]       cur_word;
    logic [W_DATA-1:0] f_par, f_act, f_rew, f_wgt;

    assign acc      = s.s_valid & s_ready_q;
    assign hdr_cnt  = s.s_data[W_CONF-1:0];
    assign s.s_ready = s_ready_q;
    // Outputs are registered from the next state, so the accepting cycle must see the live word.
    assign cur_word = acc ? s.s_data : word_q;

    tree_node_unpack u_unpack (
        .word   (cur_word),
        .parent (f_par),
        .action (f_act),
        .reward (f_rew),
        .weight (f_wgt)
    );

    always_comb begin
        state_n      = state;
        addr_n       = addr_q;
        last_n       = last_q;
        word_n       = word_q;
        conf_nodes_n = 1'b0;
        mem_par_n    = 1'b0;
        mem_act_n    = 1'b0;
        mem_rew_n    = 1'b0;
        mem_weight_n = 1'b0;
        load_done_n  = 1'b0;
        conf_data_n  = conf_data;
        mem_addr_n   = mem_addr;
        mem_data_n   = mem_data;
        tv_rst_n     = tv_rst;
        err_n        = err;
        case (state)
            S_IDLE: if (acc) begin
                if (hdr_cnt == '0 || hdr_cnt > W_CONF'(MAX_NODES)) begin
                    err_n = 1'b1;
                end else begin
                    last_n       = W_ADDR'(hdr_cnt - W_CONF'(1));
                    tv_rst_n     = 1'b1;
                    conf_nodes_n = 1'b1;
                    conf_data_n  = hdr_cnt;
                    state_n      = S_CONF;
                end
            end
            S_CONF: begin
                addr_n  = '0;
                state_n = S_NODE_WAIT;
            end
            S_NODE_WAIT: if (acc) begin
                word_n     = s.s_data;
                mem_par_n  = 1'b1;
                mem_addr_n = addr_q;
                mem_data_n = f_par;
                state_n    = S_E_PAR;
`ifdef TREE_LOADER_PARENT_CHECK_EN
                // Decided at accept time so the whole node, mem_par included, is suppressed.
                if (addr_q != '0 && f_par[W_ADDR-1:0] >= addr_q) begin
                    err_n      = 1'b1;
                    mem_par_n  = 1'b0;
                    mem_addr_n = mem_addr;
                    mem_data_n = mem_data;
                    state_n    = (addr_q == last_q) ? S_IDLE : S_DRAIN;
                end
`endif
            end
            S_E_PAR: begin
                mem_act_n  = 1'b1;
                mem_addr_n = addr_q;
                mem_data_n = f_act;
                state_n    = S_E_ACT;
            end
            S_E_ACT: begin
                mem_rew_n  = 1'b1;
                mem_addr_n = addr_q;
                mem_data_n = f_rew;
                state_n    = S_E_REW;
            end
            S_E_REW: begin
                mem_weight_n = 1'b1;
                mem_addr_n   = addr_q;
                mem_data_n   = f_wgt;
                state_n      = S_E_WGT;
            end
            S_E_WGT: begin
                if (addr_q == last_q) begin
                    load_done_n = 1'b1;
                    tv_rst_n    = 1'b0;
                    state_n     = S_DONE;
                end else begin
                    addr_n  = addr_q + W_ADDR'(1);
                    state_n = S_NODE_WAIT;
                end
            end
            S_DONE: state_n = S_IDLE;
`ifdef TREE_LOADER_PARENT_CHECK_EN
            S_DRAIN: if (acc) begin
                addr_n = addr_q + W_ADDR'(1);
                if (addr_q + W_ADDR'(1) == last_q) state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
`ifdef TREE_LOADER_PARENT_CHECK_EN
        s_ready_n = (state_n == S_IDLE) || (state_n == S_NODE_WAIT) || (state_n == S_DRAIN);
`else
        s_ready_n = (state_n == S_IDLE) || (state_n == S_NODE_WAIT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            word_q     <= '0;
            s_ready_q  <= 1'b0;
            conf_nodes <= 1'b0;
            conf_data  <= '0;
            mem_par    <= 1'b0;
            mem_act    <= 1'b0;
            mem_rew    <= 1'b0;
            mem_weight <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            tv_rst     <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            last_q     <= last_n;
            word_q     <= word_n;
            s_ready_q  <= s_ready_n;
            conf_nodes <= conf_nodes_n;
            conf_data  <= conf_data_n;
            mem_par    <= mem_par_n;
            mem_act    <= mem_act_n;
            mem_rew    <= mem_rew_n;
            mem_weight <= mem_weight_n;
            mem_addr   <= mem_addr_n;
            mem_data   <= mem_data_n;
            tv_rst     <= tv_rst_n;
            load_done  <= load_done_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_tree_loader.sv
// Scoreboard bench for tree_loader: a frame-level model queues the expected load events,
// a negedge monitor pops and compares whatever the DUT strobes.
module tb_tree_loader;
    import tree_pkg::*;

    typedef logic [31:0] wq_t[$];

    localparam int K_CONF = 1, K_PAR = 2, K_ACT = 3, K_REW = 4, K_WGT = 5, K_DONE = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              conf_nodes, mem_par, mem_act, mem_rew, mem_weight;
    logic [W_CONF-1:0] conf_data;
    logic [W_ADDR-1:0] mem_addr;
    logic [W_DATA-1:0] mem_data;
    logic              tv_rst, load_done, err;

    tree_loader_if ifc ();

    tree_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s          (ifc),
        .conf_nodes (conf_nodes),
        .conf_data  (conf_data),
        .mem_par    (mem_par),
        .mem_act    (mem_act),
        .mem_rew    (mem_rew),
        .mem_weight (mem_weight),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .tv_rst     (tv_rst),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          errs = 0;
    int          done_seen = 0;
    logic        exp_err = 1'b0;
    logic [31:0] sb[$];

    function automatic logic [31:0] ev(input int k, input int a, input int d);
        return {5'd0, k[2:0], a[11:0], d[11:0]};
    endfunction

    function automatic logic [31:0] pack(input int p, input int a, input int r, input int w);
        return {p[9:0], a[2:0], r[11:0], w[6:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a legal frame yields one conf event, four field events per node, then done.
    function automatic void exp_frame(input logic [31:0] hdr, input wq_t w);
        int cnt, p, a, r, wt;
        cnt = int'(hdr & 32'h7FF);
        if (cnt == 0 || cnt > MAX_NODES) begin
            exp_err = 1'b1;
            return;
        end
        sb.push_back(ev(K_CONF, 0, cnt));
        for (int i = 0; i < cnt; i++) begin
            p  = int'(w[i] >> 22);
            a  = int'((w[i] >> 19) & 32'h7);
            r  = int'((w[i] >> 7) & 32'hFFF);
            wt = int'(w[i] & 32'h7F);
`ifdef TREE_LOADER_PARENT_CHECK_EN
            if (i > 0 && p >= i) begin
                exp_err = 1'b1;
                return;
            end
`endif
            sb.push_back(ev(K_PAR, i, p));
            sb.push_back(ev(K_ACT, i, a));
            sb.push_back(ev(K_REW, i, r));
            sb.push_back(ev(K_WGT, i, wt));
        end
        sb.push_back(ev(K_DONE, 0, 0));
    endfunction

    function automatic wq_t rnd_frame(input int n);
        wq_t q;
        int  p;
        for (int i = 0; i < n; i++) begin
            p = (i == 0) ? int'($urandom_range(1023)) : int'($urandom_range(i - 1));
            q.push_back(pack(p, int'($urandom_range(7)), int'($urandom_range(4095)),
                             int'($urandom_range(127))));
        end
        return q;
    endfunction

    // Monitor: every strobe or load_done pulse consumes one expected event
    logic [31:0] mon_act;
    int          mon_n;
    always @(negedge clk) begin
        if (rst) begin
            mon_n = int'(conf_nodes) + int'(mem_par) + int'(mem_act) + int'(mem_rew) + int'(mem_weight);
            if (mon_n != 0) begin
                check("strobe_onehot", 32'(mon_n > 1), 0);
                if (!conf_nodes) check("ready_in_emit", 32'(ifc.s_ready), 0);
                mon_act = conf_nodes ? ev(K_CONF, 0, int'(conf_data)) :
                          mem_par    ? ev(K_PAR, int'(mem_addr), int'(mem_data)) :
                          mem_act    ? ev(K_ACT, int'(mem_addr), int'(mem_data)) :
                          mem_rew    ? ev(K_REW, int'(mem_addr), int'(mem_data)) :
                                       ev(K_WGT, int'(mem_addr), int'(mem_data));
                if (sb.size() == 0) check("unexpected_event", mon_act, 0);
                else                check("event", mon_act, sb.pop_front());
            end
            if (load_done) begin
                done_seen++;
                if (sb.size() == 0) check("unexpected_done", ev(K_DONE, 0, 0), 0);
                else                check("done_event", ev(K_DONE, 0, 0), sb.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] d, input int gap_pct);
        int n;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            ifc.s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        ifc.s_valid = 1'b1;
        ifc.s_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (ifc.s_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            if (++n > 200) begin
                check("handshake_timeout", 32'(ifc.s_ready), 1);
                break;
            end
        end
        ifc.s_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] hdr, input wq_t w, input int gap);
        int cnt;
        cnt = int'(hdr & 32'h7FF);
        exp_frame(hdr, w);
        send(hdr, gap);
        if (cnt != 0 && cnt <= MAX_NODES) begin
            check("tv_rst_during_load", 32'(tv_rst), 1);
            foreach (w[i]) send(w[i], gap);
        end
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, vecs=%0d", vecs);
        $fatal(1, "watchdog");
    end

    initial begin
        wq_t w;
        int  d0;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        #12;
        check("rst_strobes", 32'({conf_nodes, mem_par, mem_act, mem_rew, mem_weight,
                                  load_done, ifc.s_ready, err}), 0);
        check("rst_bus", 32'({conf_data, mem_addr}), 0);
        check("rst_data", 32'(mem_data), 0);
        check("rst_tv", 32'(tv_rst), 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed three-node frame
        w = {pack(0, 5, 'h123, 7), pack(0, 1, 'h0FA, 50), pack(0, 2, 'h800, 100)};
        load(3, w, 0);
        wait_sb();
        check("t1_done_count", 32'(done_seen), 1);
        check("t1_tv_rst", 32'(tv_rst), 0);
        check("t1_err", 32'(err), 0);

        // Illegal headers, then a legal one-node frame
        send(0, 0);
        exp_err = 1'b1;
        check("hdr0_err", 32'(err), 1);
        @(negedge clk);
        check("hdr0_ready", 32'(ifc.s_ready), 1);
        @(posedge clk);
        #1;
        send(1025, 0);
        check("hdr1025_err", 32'(err), 1);
        check("hdr1025_tv", 32'(tv_rst), 0);
        load(1, rnd_frame(1), 0);
        wait_sb();
        check("t2_done_count", 32'(done_seen), 2);

        // Gappy upstream, junk in the header's upper bits
        load(32'hABCDE000 | 32'd4, rnd_frame(4), 50);
        wait_sb();
        check("t3_done_count", 32'(done_seen), 3);

        // Async reset in the middle of node 2
        w = rnd_frame(5);
        exp_frame(5, w);
        send(5, 0);
        send(w[0], 0);
        send(w[1], 0);
        send(w[2], 0);
        d0 = done_seen;
        #2 rst = 1'b0;
        #1;
        check("arst_strobes", 32'({conf_nodes, mem_par, mem_act, mem_rew, mem_weight, load_done}), 0);
        check("arst_tv", 32'(tv_rst), 1);
        check("arst_err", 32'(err), 0);
        sb.delete();
        exp_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        load(2, rnd_frame(2), 0);
        wait_sb();
        check("arst_done_count", 32'(done_seen - d0), 1);
        check("arst_err_after", 32'(err), 32'(exp_err));

`ifdef TREE_LOADER_PARENT_CHECK_EN
        // Forward-pointing parent on node 2 of 4
        d0 = done_seen;
        w = {pack(0, 1, 1, 1), pack(0, 2, 2, 2), pack(3, 3, 3, 3), pack(1, 4, 4, 4)};
        load(4, w, 0);
        wait_sb();
        check("pchk_err", 32'(err), 1);
        check("pchk_tv", 32'(tv_rst), 1);
        check("pchk_no_done", 32'(done_seen - d0), 0);
        load(1, rnd_frame(1), 0);
        wait_sb();
        check("pchk_next_hdr", 32'(done_seen - d0), 1);
`endif

        // Largest legal frame
        d0 = done_seen;
        load(1024, rnd_frame(1024), 0);
        wait_sb();
        check("max_done_once", 32'(done_seen - d0), 1);
        check("max_last_addr", 32'(mem_addr), 1023);
        check("max_err", 32'(err), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
